// File: rtl/crc_frame_ctrl_pkg.sv
// Shared types and widths for the CRC-8 frame sequencer.
package crc_frame_ctrl_pkg;

  localparam int CRC_W     = 8;
  localparam int BIT_CNT_W = 3;
  localparam int BYTE_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SEED    = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_ERR     = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/crc_byte_hold.sv
// One-entry byte holding register (data + last flag) with ready/valid input.
// A load and an unload in the same cycle leave the register full with the new byte.
module crc_byte_hold
  import crc_frame_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_last,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_unload,
  input  logic              i_flush,
  output logic              o_full,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_last
);

  logic              r_full;
  logic [BYTE_W-1:0] r_data;
  logic              r_last;
  logic              w_load;

  assign o_ready = !r_full;
  assign w_load  = i_valid && !r_full;
  assign o_full  = r_full;
  assign o_data  = r_data;
  assign o_last  = r_last;

  // Load has priority so a byte taken in the same cycle as an unload is kept.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_full <= 1'b0;
      r_data <= '0;
      r_last <= 1'b0;
    end else if (w_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
      r_last <= i_last;
    end else if (i_unload || i_flush) begin
      r_full <= 1'b0;
    end
  end

endmodule

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for a serial CRC-8 engine: serialises bytes LSB-first with
// an unbroken shift window, then gathers the engine's serial CRC bits.
//
// state   | meaning
// IDLE    | waiting for the first byte of a frame in the holding register
// SEED    | one-cycle engine reseed (ENG_RST_N low)
// SHIFT   | ENG_ACTIVE high, one frame bit per cycle, bytes chained without gaps
// COLLECT | gathering 8 CRC bits from the engine, with timeout
// ERR     | one-cycle abort marker (underrun or timeout)
// DONE    | result held until OUT_READY
module crc_frame_ctrl
  import crc_frame_ctrl_pkg::*;
#(
  parameter int COLLECT_TIMEOUT = 16,
  parameter int CNT_W           = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_in_data,
  input  logic              i_in_valid,
  input  logic              i_in_last,
  output logic              o_in_ready,
  output logic              o_eng_data,
  output logic              o_eng_active,
  output logic              o_eng_rst_n,
  input  logic              i_eng_crc,
  input  logic              i_eng_valid,
  output logic [CRC_W-1:0]  o_out_crc,
  output logic              o_out_err,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic              o_busy,
  output logic [CNT_W-1:0]  o_byte_cnt
);

  localparam int TMO_W = $clog2(COLLECT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(COLLECT_TIMEOUT);

  state_t                 r_state;
  logic [BYTE_W-1:0]      r_shreg;
  logic                   r_cur_last;
  logic [BIT_CNT_W-1:0]   r_bit;
  logic [BIT_CNT_W-1:0]   r_samp;
  logic [CRC_W-1:0]       r_crc;
  logic [TMO_W-1:0]       r_tmo;
  logic                   r_underrun;
  logic                   r_eng_data;
  logic                   r_eng_active;
  logic                   r_eng_rst_n;
  logic [CRC_W-1:0]       r_out_crc;
  logic                   r_out_err;
  logic                   r_out_valid;
  logic [CNT_W-1:0]       r_byte_cnt;

  logic                   w_hold_full;
  logic [BYTE_W-1:0]      w_hold_data;
  logic                   w_hold_last;
  logic                   w_unload;
  logic                   w_flush;
  logic                   w_bit_end;
  logic [BIT_CNT_W-1:0]   w_next_bit;
  logic [CRC_W-1:0]       w_crc_next;

  assign w_bit_end  = (r_bit == '1);
  assign w_next_bit = r_bit + 1'b1;
  assign w_crc_next = {i_eng_crc, r_crc[CRC_W-1:1]};

  // A byte leaves the holding register when it starts a frame or chains onto one.
  assign w_unload = (r_state == ST_SEED) ||
                    ((r_state == ST_SHIFT) && w_bit_end && !r_cur_last && w_hold_full);
  // After an underrun, a byte that landed together with the abort is the late
  // tail of the dead frame; anything loaded later is a fresh frame and is kept.
  assign w_flush  = (r_state == ST_ERR) && r_underrun;

  crc_byte_hold u_hold (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_data   (i_in_data),
    .i_last   (i_in_last),
    .i_valid  (i_in_valid),
    .o_ready  (o_in_ready),
    .i_unload (w_unload),
    .i_flush  (w_flush),
    .o_full   (w_hold_full),
    .o_data   (w_hold_data),
    .o_last   (w_hold_last)
  );

  // Frame sequencer with registered engine and result outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_shreg      <= '0;
      r_cur_last   <= 1'b0;
      r_bit        <= '0;
      r_samp       <= '0;
      r_crc        <= '0;
      r_tmo        <= '0;
      r_underrun   <= 1'b0;
      r_eng_data   <= 1'b0;
      r_eng_active <= 1'b0;
      r_eng_rst_n  <= 1'b1;
      r_out_crc    <= '0;
      r_out_err    <= 1'b0;
      r_out_valid  <= 1'b0;
      r_byte_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_hold_full) begin
            r_state     <= ST_SEED;
            r_byte_cnt  <= '0;
            r_eng_rst_n <= 1'b0;
            r_out_crc   <= '0;
            r_out_err   <= 1'b0;
          end
        end
        ST_SEED: begin
          r_state      <= ST_SHIFT;
          r_eng_rst_n  <= 1'b1;
          r_eng_active <= 1'b1;
          r_shreg      <= w_hold_data;
          r_cur_last   <= w_hold_last;
          r_eng_data   <= w_hold_data[0];
          r_bit        <= '0;
        end
        ST_SHIFT: begin
          if (!w_bit_end) begin
            r_bit      <= w_next_bit;
            r_eng_data <= r_shreg[w_next_bit];
          end else begin
            if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 1'b1;
            if (r_cur_last) begin
              r_state      <= ST_COLLECT;
              r_eng_active <= 1'b0;
              r_eng_data   <= 1'b0;
              r_samp       <= '0;
              r_crc        <= '0;
              r_tmo        <= TMO_LOAD;
            end else if (w_hold_full) begin
              r_shreg    <= w_hold_data;
              r_cur_last <= w_hold_last;
              r_eng_data <= w_hold_data[0];
              r_bit      <= '0;
            end else begin
              // Any gap in ENG_ACTIVE corrupts the engine LFSR, so abort.
              r_state      <= ST_ERR;
              r_eng_active <= 1'b0;
              r_eng_data   <= 1'b0;
              r_underrun   <= 1'b1;
              r_out_crc    <= '0;
              r_out_err    <= 1'b1;
            end
          end
        end
        ST_COLLECT: begin
          if (i_eng_valid) begin
            r_crc  <= w_crc_next;
            r_samp <= r_samp + 1'b1;
            r_tmo  <= TMO_LOAD;
            if (r_samp == '1) begin
              r_state     <= ST_DONE;
              r_out_crc   <= w_crc_next;
              r_out_err   <= 1'b0;
              r_out_valid <= 1'b1;
            end
          end else if (r_tmo <= TMO_W'(1)) begin
            r_state    <= ST_ERR;
            r_underrun <= 1'b0;
            r_out_crc  <= '0;
            r_out_err  <= 1'b1;
          end else begin
            r_tmo <= r_tmo - 1'b1;
          end
        end
        ST_ERR: begin
          r_state     <= ST_DONE;
          r_underrun  <= 1'b0;
          r_out_valid <= 1'b1;
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_eng_data   = r_eng_data;
  assign o_eng_active = r_eng_active;
  assign o_eng_rst_n  = r_eng_rst_n;
  assign o_out_crc    = r_out_crc;
  assign o_out_err    = r_out_err;
  assign o_out_valid  = r_out_valid;
  assign o_busy       = (r_state != ST_IDLE);
  assign o_byte_cnt   = r_byte_cnt;

endmodule

// File: tb/tb_crc_frame_ctrl.sv
`timescale 1ns/1ps
// Bench for crc_frame_ctrl: bit-serial CRC-8 engine model, result scoreboard.
module tb_crc_frame_ctrl;

  localparam int TMO   = 16;
  localparam int CNT_W = 16;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b1;
  logic [7:0]       i_in_data = '0;
  logic             i_in_valid = 1'b0;
  logic             i_in_last = 1'b0;
  logic             o_in_ready;
  logic             o_eng_data;
  logic             o_eng_active;
  logic             o_eng_rst_n;
  logic             i_eng_crc = 1'b0;
  logic             i_eng_valid = 1'b0;
  logic [7:0]       o_out_crc;
  logic             o_out_err;
  logic             o_out_valid;
  logic             i_out_ready = 1'b1;
  logic             o_busy;
  logic [CNT_W-1:0] o_byte_cnt;

  crc_frame_ctrl #(.COLLECT_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_in_data    (i_in_data),
    .i_in_valid   (i_in_valid),
    .i_in_last    (i_in_last),
    .o_in_ready   (o_in_ready),
    .o_eng_data   (o_eng_data),
    .o_eng_active (o_eng_active),
    .o_eng_rst_n  (o_eng_rst_n),
    .i_eng_crc    (i_eng_crc),
    .i_eng_valid  (i_eng_valid),
    .o_out_crc    (o_out_crc),
    .o_out_err    (o_out_err),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_busy       (o_busy),
    .o_byte_cnt   (o_byte_cnt)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0]       crc;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;
  typedef logic [7:0] bq_t[$];

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_err = 0;
  int   n_out = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // CRC-8, polynomial 0x07, one input bit per step.
  function automatic logic [7:0] crc_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_frame(input bq_t bytes);
    logic [7:0] c;
    c = 8'h00;
    foreach (bytes[i])
      for (int k = 0; k < 8; k++) c = crc_step(c, bytes[i][k]);
    return c;
  endfunction

  // Engine model: reseeds on ENG_RST_N low, shifts while ENG_ACTIVE, and
  // streams its 8 CRC bits a few cycles after ENG_ACTIVE falls.
  logic [7:0] eng_lfsr = 8'h00;
  int         eng_k = 8;
  int         eng_wait = 0;
  logic       eng_prev = 1'b0;
  logic       eng_mute = 1'b0;

  always @(negedge i_clk) begin
    if (eng_k < 8) begin
      i_eng_valid = 1'b1;
      i_eng_crc   = eng_lfsr[eng_k];
      eng_k++;
    end else begin
      i_eng_valid = 1'b0;
      i_eng_crc   = 1'b0;
    end
    if (eng_wait > 0) begin
      eng_wait--;
      if (eng_wait == 0) eng_k = 0;
    end
    if (!o_eng_rst_n) begin
      eng_lfsr = 8'h00;
      eng_k    = 8;
      eng_wait = 0;
    end else if (o_eng_active) begin
      eng_lfsr = crc_step(eng_lfsr, o_eng_data);
    end
    if (eng_prev && !o_eng_active && !eng_mute) eng_wait = 2;
    eng_prev = o_eng_active;
  end

  // Observers: shift-window length, seed cycles, serial bits, timeout distance.
  int   run = 0;
  int   last_run = 0;
  int   seed_cyc = 0;
  int   tmo_cnt = 0;
  int   tmo_meas = -1;
  logic tmo_trk = 1'b0;
  logic obs_prev = 1'b0;
  logic bit_q[$];

  always @(negedge i_clk) begin
    if (!i_rst && !o_eng_rst_n) seed_cyc++;
    if (o_eng_active) bit_q.push_back(o_eng_data);
    if (obs_prev && !o_eng_active) begin
      last_run = run;
      run      = 0;
      tmo_cnt  = 0;
      tmo_trk  = 1'b1;
    end else if (tmo_trk) begin
      tmo_cnt++;
      if (o_out_err) begin
        tmo_meas = tmo_cnt;
        tmo_trk  = 1'b0;
      end
    end
    if (o_eng_active) run++;
    obs_prev = o_eng_active;
  end

  // Result monitor: pops one expectation per OUT_VALID assertion.
  logic mon_seen = 1'b0;
  always @(negedge i_clk) begin
    if (o_out_valid && !mon_seen) begin
      mon_seen = 1'b1;
      n_out++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_out", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("out_crc", o_out_crc, mon_e.crc);
        chk("out_err", o_out_err, mon_e.err);
        chk("byte_cnt", o_byte_cnt, mon_e.cnt);
      end
    end else if (!o_out_valid) begin
      mon_seen = 1'b0;
    end
  end

  task automatic put_byte(input logic [7:0] d, input logic l);
    int n = 0;
    i_in_data  = d;
    i_in_last  = l;
    i_in_valid = 1'b1;
    while (!o_in_ready && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    if (n >= 200) chk("in_ready_wait", 32'd0, 32'd1);
    @(negedge i_clk);
    i_in_valid = 1'b0;
    i_in_last  = 1'b0;
  endtask

  task automatic send_frame(input bq_t bytes);
    exp_t e;
    e.crc = crc_frame(bytes);
    e.err = 1'b0;
    e.cnt = CNT_W'(bytes.size());
    sb_q.push_back(e);
    foreach (bytes[i]) put_byte(bytes[i], (i == bytes.size() - 1));
  endtask

  task automatic push_err(input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.crc = 8'h00;
    e.err = 1'b1;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_outs(input int target);
    int n = 0;
    while (n_out < target && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk("out_count", n_out, target);
    repeat (2) @(negedge i_clk);
  endtask

  initial begin
    bq_t  fr;
    int   seeds0;
    int   bad;
    int   n;
    logic [7:0] snap_crc;
    logic       snap_err;
    logic [7:0] v;

    // Reset values
    repeat (3) @(negedge i_clk);
    chk("rst_in_ready", o_in_ready, 1);
    chk("rst_eng_data", o_eng_data, 0);
    chk("rst_eng_active", o_eng_active, 0);
    chk("rst_eng_rst_n", o_eng_rst_n, 1);
    chk("rst_out_crc", o_out_crc, 0);
    chk("rst_out_err", o_out_err, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_byte_cnt", o_byte_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);

    // Single zero byte
    seeds0 = seed_cyc;
    fr = '{8'h00};
    send_frame(fr);
    wait_outs(1);
    chk("t1_active_run", last_run, 8);
    chk("t1_seed_cycles", seed_cyc - seeds0, 1);

    // Back-to-back three-byte frame
    bit_q.delete();
    fr = '{8'hA5, 8'h3C, 8'h01};
    send_frame(fr);
    wait_outs(2);
    chk("t2_active_run", last_run, 24);
    chk("t2_bit_count", bit_q.size(), 24);
    v = '0;
    if (bit_q.size() >= 24) for (int i = 0; i < 8; i++) v[i] = bit_q[i];
    chk("t2_lsb_first_b0", v, 8'hA5);
    v = '0;
    if (bit_q.size() >= 24) for (int i = 0; i < 8; i++) v[i] = bit_q[16 + i];
    chk("t2_lsb_first_b2", v, 8'h01);

    // Underrun, then a frame that must reseed
    push_err(1);
    put_byte(8'h11, 1'b0);
    wait_outs(3);
    chk("t3_active_run", last_run, 8);
    seeds0 = seed_cyc;
    fr = '{8'h3C};
    send_frame(fr);
    wait_outs(4);
    chk("t3_reseed", seed_cyc - seeds0, 1);

    // Collect timeout with a silent engine
    eng_mute = 1'b1;
    tmo_meas = -1;
    push_err(1);
    put_byte(8'h5A, 1'b1);
    wait_outs(5);
    chk("t4_timeout_cycles", tmo_meas, TMO);
    eng_mute = 1'b0;

    // Output backpressure while the next frame's first byte arrives
    i_out_ready = 1'b0;
    fr = '{8'h77};
    send_frame(fr);
    n = 0;
    while (n_out < 6 && n < 400) begin
      @(negedge i_clk);
      n++;
    end
    chk("t5_out_count", n_out, 6);
    snap_crc = o_out_crc;
    snap_err = o_out_err;
    bad = 0;
    fr = '{8'h42};
    for (int c = 0; c < 10; c++) begin
      if (c == 0) begin
        i_in_data  = 8'h42;
        i_in_last  = 1'b1;
        i_in_valid = 1'b1;
      end else begin
        i_in_valid = 1'b0;
        i_in_last  = 1'b0;
      end
      @(negedge i_clk);
      if (!o_out_valid || o_out_crc !== snap_crc || o_out_err !== snap_err) bad++;
    end
    chk("t5_out_stable", bad, 0);
    chk("t5_in_ready_full", o_in_ready, 0);
    begin
      exp_t e;
      e.crc = crc_frame(fr);
      e.err = 1'b0;
      e.cnt = 1;
      sb_q.push_back(e);
    end
    i_out_ready = 1'b1;
    @(negedge i_clk);
    chk("t5_idle_busy", o_busy, 0);
    chk("t5_idle_rst_n", o_eng_rst_n, 1);
    @(negedge i_clk);
    chk("t5_seed_next", o_eng_rst_n, 0);
    wait_outs(7);

    // Reset in the middle of SHIFT
    put_byte(8'h99, 1'b1);
    n = 0;
    while (!o_eng_active && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("t6_shift_seen", o_eng_active, 1);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("t6_rst_outputs",
        {o_in_ready, o_eng_data, o_eng_active, o_eng_rst_n, o_out_crc,
         o_out_err, o_out_valid, o_busy},
        {1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("t6_rst_byte_cnt", o_byte_cnt, 0);
    i_rst = 1'b0;
    @(negedge i_clk);
    fr = '{8'h00};
    send_frame(fr);
    wait_outs(8);

    repeat (40) @(negedge i_clk);
    chk("sb_drained", sb_q.size(), 0);
    chk("no_extra_out", n_out, 8);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
